// File: rtl/trig_surf_gather.sv
`default_nettype none
// ============================================================================
// Module   : trig_surf_gather
// Brief    : Aligns SURF trigger lanes to the sysclk command phase, buffers one
//            word per SURF, and streams pending words round-robin over AXI4-S.
// Revision : 1.0
// ============================================================================
module trig_surf_gather #(
    parameter int NTIO          = 4,
    parameter int TIO_PORTS     = 8,
    parameter int SURFS_PER_TIO = 7,
    parameter int DW            = 16,
    parameter int CYCLE         = 8,
    parameter int SLOTS         = 2,
    parameter int FIRST_OFFSET  = 2,
    parameter int SLOT_SPACING  = 4
) (
    input  logic                               sysclk_i,
    input  logic                               sysclk_rst_i,
    input  logic                               sysclk_phase_i,
    input  logic [NTIO*TIO_PORTS*DW-1:0]       trig_dat_i,
    input  logic [NTIO*SURFS_PER_TIO-1:0]      trig_mask_i,
    input  logic                               stat_clr_i,
    output logic [DW+7:0]                      trigout_tdata,
    output logic                               trigout_tvalid,
    input  logic                               trigout_tready,
    output logic                               locked_o,
    output logic                               misalign_o,
    output logic [15:0]                        overflow_count_o,
    output logic [NTIO*SURFS_PER_TIO-1:0]      pending_o
);

    localparam int N  = NTIO * SURFS_PER_TIO;
    localparam int CW = (CYCLE > 2) ? $clog2(CYCLE) : 1;
    localparam int PW = (N > 2) ? $clog2(N) : 1;

    generate
        if (FIRST_OFFSET + (SLOTS - 1) * SLOT_SPACING >= CYCLE) begin : g_cfg_err
            $error("trig_surf_gather: last slot falls outside the command cycle");
        end
    endgenerate

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            locked_q, locked_d;
    logic            misalign_q, misalign_d;
    logic [15:0]     ovf_q, ovf_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [DW+7:0]   tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d;
    logic [DW-1:0]   hold_q [N];
    logic [DW-1:0]   hold_d [N];

    logic [DW-1:0]   lane_word [N];
    logic            strobe;
    logic [N-1:0]    hit;
    logic [N-1:0]    avail;
    logic            load;
    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic [16:0]     drops;
    logic [16:0]     ovf_sum;
    logic            unused_lanes;

    // Spare physical ports carry no SURF; fold them away explicitly.
    assign unused_lanes = ^trig_dat_i;

    generate
        for (genvar t = 0; t < NTIO; t++) begin : g_tio
            for (genvar j = 0; j < SURFS_PER_TIO; j++) begin : g_surf
                assign lane_word[t*SURFS_PER_TIO + j] = trig_dat_i[(t*TIO_PORTS + j)*DW +: DW];
            end
        end
    endgenerate

    always_comb begin
        cnt_d      = cnt_q;
        locked_d   = locked_q | sysclk_phase_i;
        misalign_d = misalign_q;
        if (sysclk_phase_i) begin
            cnt_d = CW'(1);
            if (locked_q && (cnt_q != '0)) misalign_d = 1'b1;
        end else if (cnt_q == CW'(CYCLE - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (stat_clr_i) misalign_d = 1'b0;

        strobe = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            if (locked_q && (cnt_q == CW'(FIRST_OFFSET + k*SLOT_SPACING))) strobe = 1'b1;
        end
    end

    // Arbitration sees both held words and fresh hits, so a new trigger can
    // bypass the hold register and reach the output on its strobe clock.
    always_comb begin
        int idx;
        idx = 0;
        for (int s = 0; s < N; s++) begin
            hit[s] = strobe & lane_word[s][DW-1] & ~trig_mask_i[s];
        end
        avail     = pending_q | hit;
        load      = ~tvalid_q | trigout_tready;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + 1 + i;
            if (idx >= N) idx = idx - N;
            if (idx >= N) idx = idx - N;
            if (!gnt_found && avail[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        ptr_d     = ptr_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        drops     = '0;
        for (int s = 0; s < N; s++) hold_d[s] = hold_q[s];

        if (load) begin
            if (gnt_found) begin
                tvalid_d = 1'b1;
                ptr_d    = gnt_idx;
                tdata_d  = {8'(gnt_idx), pending_q[gnt_idx] ? hold_q[gnt_idx] : lane_word[gnt_idx]};
            end else begin
                tvalid_d = 1'b0;
            end
        end

        for (int s = 0; s < N; s++) begin
            if (load && gnt_found && (gnt_idx == PW'(s))) begin
                // Granted while re-hit: old word leaves, new word takes its place.
                pending_d[s] = pending_q[s] & hit[s];
                if (pending_q[s] && hit[s]) hold_d[s] = lane_word[s];
            end else if (hit[s]) begin
                if (!pending_q[s]) begin
                    pending_d[s] = 1'b1;
                    hold_d[s]    = lane_word[s];
                end else begin
                    drops = drops + 17'd1;
                end
            end
        end

        ovf_sum = {1'b0, ovf_q} + drops;
        if (stat_clr_i)      ovf_d = '0;
        else if (ovf_sum[16]) ovf_d = 16'hFFFF;
        else                 ovf_d = ovf_sum[15:0];
    end

    always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
        if (sysclk_rst_i) begin
            cnt_q      <= '0;
            locked_q   <= 1'b0;
            misalign_q <= 1'b0;
            ovf_q      <= '0;
            pending_q  <= '0;
            ptr_q      <= PW'(N - 1);
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            for (int s = 0; s < N; s++) hold_q[s] <= '0;
        end else begin
            cnt_q      <= cnt_d;
            locked_q   <= locked_d;
            misalign_q <= misalign_d;
            ovf_q      <= ovf_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            for (int s = 0; s < N; s++) hold_q[s] <= hold_d[s];
        end
    end

    assign trigout_tdata    = tdata_q;
    assign trigout_tvalid   = tvalid_q;
    assign locked_o         = locked_q;
    assign misalign_o       = misalign_q;
    assign overflow_count_o = ovf_q;
    assign pending_o        = pending_q;

endmodule
`default_nettype wire
